// File: rtl/ps2_smg_ctrlmod_if.sv
// rtl/ps2_smg_ctrlmod_if.sv - byte-in / display-word-out signal bundle for ps2_smg_ctrlmod
interface ps2_smg_ctrlmod_if;
  logic        iTrig;
  logic [7:0]  iData;
  logic        iClear;
  logic [23:0] oData;
  logic [2:0]  oExt;
  logic        oTrig;
  logic [7:0]  oHeld;

  // Receiver / clear source side
  modport master (
    output iTrig,
    output iData,
    output iClear,
    input  oData,
    input  oExt,
    input  oTrig,
    input  oHeld
  );

  // Sequencer side
  modport slave (
    input  iTrig,
    input  iData,
    input  iClear,
    output oData,
    output oExt,
    output oTrig,
    output oHeld
  );
endinterface

// File: rtl/ps2_smg_ctrlmod.sv
// rtl/ps2_smg_ctrlmod.sv - PS/2 scan-code sequencer feeding a 3-key history to a 6-digit display (option: PS2_TYPEMATIC_FILTER_EN)
module ps2_smg_ctrlmod #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic             CLOCK,
  input  logic             RESET,
  ps2_smg_ctrlmod_if.slave bus
);

  localparam logic [7:0]  CODE_EXT = 8'hE0;
  localparam logic [7:0]  CODE_BRK = 8'hF0;
  localparam logic [19:0] CNT_LAST = 20'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BREAK,
    ST_EXT_BREAK
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [23:0] data_q, data_d;
  logic [2:0]  ext_q, ext_d;
  logic [7:0]  held_q, held_d;
  logic        trig_q, trig_d;

  logic        make_v;
  logic        make_ext;
  logic        rel_v;
  logic        repeat_drop;
  logic        do_push;

  // The held key is always the newest history entry (or zero after a release
  // or clear), so its ext flag is ext_q[0]; no separate register is needed.
`ifdef PS2_TYPEMATIC_FILTER_EN
  assign repeat_drop = (bus.iData == held_q) && (make_ext == ext_q[0]);
`else
  assign repeat_drop = 1'b0;
`endif

  assign do_push = make_v && !repeat_drop;

  // Prefix decoder: classifies each strobed byte and runs the prefix timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    make_v   = 1'b0;
    make_ext = 1'b0;
    rel_v    = 1'b0;
    if (bus.iTrig) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.iData == CODE_EXT) begin
            state_d = ST_EXT;
          end else if (bus.iData == CODE_BRK) begin
            state_d = ST_BREAK;
          end else begin
            make_v = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.iData == CODE_BRK) begin
            state_d = ST_EXT_BREAK;
          end else begin
            make_v   = 1'b1;
            make_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BREAK, ST_EXT_BREAK: begin
          // Any byte here, including E0/F0, is the released code
          rel_v   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // History, ext flags and held key; clear overrides a push in the same cycle
  always_comb begin
    data_d = data_q;
    ext_d  = ext_q;
    held_d = held_q;
    trig_d = 1'b0;
    if (bus.iClear) begin
      data_d = '0;
      ext_d  = '0;
      held_d = '0;
    end else if (do_push) begin
      data_d = {data_q[15:0], bus.iData};
      ext_d  = {ext_q[1:0], make_ext};
      held_d = bus.iData;
      trig_d = 1'b1;
    end else if (rel_v && (bus.iData == held_q)) begin
      held_d = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      ext_q   <= '0;
      held_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ext_q   <= ext_d;
      held_q  <= held_d;
      trig_q  <= trig_d;
    end
  end

  assign bus.oData = data_q;
  assign bus.oExt  = ext_q;
  assign bus.oHeld = held_q;
  assign bus.oTrig = trig_q;

endmodule

// File: tb/tb_ps2_smg_ctrlmod.sv
// tb/tb_ps2_smg_ctrlmod.sv - scoreboard bench for ps2_smg_ctrlmod
module tb_ps2_smg_ctrlmod;

  localparam int T = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_smg_ctrlmod_if bus ();

  ps2_smg_ctrlmod #(.TIMEOUT_CYC(T)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] d;
    logic [2:0]  e;
    logic [7:0]  h;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: key history as an array (index 0 newest) and prefix flags
  logic [7:0] m_key[3];
  bit         m_ext[3];
  logic [7:0] m_held;
  bit         m_hext;
  bit         saw_e0, saw_f0;
  int         idle_cnt;

  function automatic logic [23:0] m_data();
    return {m_key[2], m_key[1], m_key[0]};
  endfunction

  function automatic logic [2:0] m_exts();
    return {m_ext[2], m_ext[1], m_ext[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_key[i] = 8'h00;
      m_ext[i] = 1'b0;
    end
    m_held = 8'h00;
    m_hext = 1'b0;
    saw_e0 = 1'b0;
    saw_f0 = 1'b0;
    idle_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit trig, input logic [7:0] b, input bit clr);
    bit pushed = 1'b0;
    bit drop;
    if (trig) begin
      idle_cnt = 0;
      if (saw_f0) begin
        if (b == m_held) m_held = 8'h00;
        saw_f0 = 1'b0;
        saw_e0 = 1'b0;
      end else if (b == 8'hF0) begin
        saw_f0 = 1'b1;
      end else if (b == 8'hE0 && !saw_e0) begin
        saw_e0 = 1'b1;
      end else begin
        drop = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        drop = (b == m_held) && (saw_e0 == m_hext);
`endif
        if (!drop && !clr) begin
          m_key[2] = m_key[1]; m_ext[2] = m_ext[1];
          m_key[1] = m_key[0]; m_ext[1] = m_ext[0];
          m_key[0] = b;        m_ext[0] = saw_e0;
          m_held = b;
          m_hext = saw_e0;
          pushed = 1'b1;
        end
        saw_e0 = 1'b0;
      end
    end else if (saw_e0 || saw_f0) begin
      idle_cnt++;
      if (idle_cnt >= T) begin
        saw_e0 = 1'b0;
        saw_f0 = 1'b0;
        idle_cnt = 0;
      end
    end
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        m_key[i] = 8'h00;
        m_ext[i] = 1'b0;
      end
      m_held = 8'h00;
      m_hext = 1'b0;
    end
    if (pushed) exp_q.push_back('{d: m_data(), e: m_exts(), h: m_held});
  endtask

  task automatic cycle(input bit trig, input logic [7:0] b, input bit clr);
    bus.iTrig  = trig;
    bus.iData  = b;
    bus.iClear = clr;
    @(posedge clk);
    model_step(trig, b, clr);
    #1;
    bus.iTrig  = 1'b0;
    bus.iClear = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"}, 32'(bus.oData), 32'(m_data()));
    check({tag, "_ext"},  32'(bus.oExt),  32'(m_exts()));
    check({tag, "_held"}, 32'(bus.oHeld), 32'(m_held));
  endtask

  task automatic drain(input string tag);
    idle(2);
    check({tag, "_pending_pushes"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every oTrig pulse must match the oldest expected push
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.oTrig === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_oTrig", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("mon_data", 32'(bus.oData), 32'(e.d));
          check("mon_ext",  32'(bus.oExt),  32'(e.e));
          check("mon_held", 32'(bus.oHeld), 32'(e.h));
        end
      end
    end
  end

  initial begin
    logic [7:0] codes[6];
    logic [7:0] b;
    int r;
    codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21;
    codes[3] = 8'h23; codes[4] = 8'h75; codes[5] = 8'h29;
    bus.iTrig = 1'b0; bus.iData = 8'h00; bus.iClear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();
    check("rst_data",  32'(bus.oData), 32'h0);
    check("rst_ext",   32'(bus.oExt),  32'h0);
    check("rst_held",  32'(bus.oHeld), 32'h0);
    check("rst_trig",  32'(bus.oTrig), 32'h0);

    // Make, break of the same key
    send(8'h1C);
    check("tp1_held_make", 32'(bus.oHeld), 32'h1C);
    send(8'hF0); send(8'h1C);
    check("tp1_data", 32'(bus.oData), 32'h00001C);
    check("tp1_held_rel", 32'(bus.oHeld), 32'h00);
    drain("tp1");

    // Four makes shift the oldest out
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    check("tp2_data", 32'(bus.oData), 32'h322123);
    drain("tp2");

    // Extended make and extended break
    do_reset();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("tp3_low", 32'(bus.oData[7:0]), 32'h75);
    check("tp3_ext0", 32'(bus.oExt[0]), 32'h1);
    check("tp3_held", 32'(bus.oHeld), 32'h00);
    send(8'h29);
    check("tp3_idle_after", 32'(bus.oExt[0]), 32'h0);
    drain("tp3");

    // Typematic repeats
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("tp4_data", 32'(bus.oData), 32'h001C1C);
`else
    check("tp4_data", 32'(bus.oData), 32'h1C1C1C);
`endif
    check_state("tp4");
    drain("tp4");

    // Prefix timeout and its exact boundary
    do_reset();
    send(8'hE0); idle(T + 2); send(8'h29);
    check("tp5_low", 32'(bus.oData[7:0]), 32'h29);
    check("tp5_ext0", 32'(bus.oExt[0]), 32'h0);
    send(8'hE0); idle(T - 1); send(8'h75);
    check("to_edge_ext0", 32'(bus.oExt[0]), 32'h1);
    send(8'hE0); idle(T); send(8'h75);
    check("to_expired_ext0", 32'(bus.oExt[0]), 32'h0);
    check_state("tp5");
    drain("tp5");

    // Clear racing a push, then reset in BREAK
    send(8'h32);
    cycle(1'b1, 8'h1C, 1'b1);
    check("tp6_clr_data", 32'(bus.oData), 32'h000000);
    check("tp6_clr_held", 32'(bus.oHeld), 32'h00);
    send(8'hF0);
    do_reset();
    send(8'h1C);
    check("tp6_after_rst", 32'(bus.oData), 32'h00001C);
    drain("tp6");

    // Randomized byte stream
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else             b = codes[$urandom_range(0, 5)];
      cycle($urandom_range(0, 9) < 8, b, $urandom_range(0, 49) == 0);
      if (i % 50 == 49) check_state("rand");
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
